// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised VGA timing generator. Divides ref_clk down to a
//                pixel tick, runs horizontal/vertical counters, produces
//                sync/blank levels delayed by PIPE pixel stages, line/frame
//                strobes, a frame counter and a frame-boundary run/stop FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int PIPE     = 2,
    parameter int CW       = 10
) (
    input  logic          ref_clk,
    input  logic          rst,
    input  logic          en,
    output logic          vga_clk,
    output logic          pix_en,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic          h_sync,
    output logic          v_sync,
    output logic          sync_b,
    output logic          blank_b,
    output logic [15:0]   frame_cnt,
    output logic          running
);

    localparam int c_h_max  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_max  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hs_beg = H_ACTIVE + H_FP;
    localparam int c_hs_end = H_ACTIVE + H_FP + H_SYNC;
    localparam int c_vs_beg = V_ACTIVE + V_FP;
    localparam int c_vs_end = V_ACTIVE + V_FP + V_SYNC;
    localparam int c_dw     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic c_h_on = (H_POL != 0);
    localparam logic c_v_on = (V_POL != 0);
    // {h_sync, v_sync, sync_b, blank_b} when nothing is being displayed
    localparam logic [3:0] c_inact = {~c_h_on, ~c_v_on, 1'b1, 1'b0};

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    logic [c_dw-1:0] r_div_cnt;
    logic [c_dw-1:0] w_div_nxt;
    logic            w_tick;
    logic            r_vga_clk;
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            w_running;
    logic [CW-1:0]   r_x;
    logic [CW-1:0]   r_y;
    logic [15:0]     r_frame_cnt;
    logic            w_x_last;
    logic            w_y_last;
    logic            w_wrap;
    logic            w_active;
    logic            w_hs_act;
    logic            w_vs_act;
    logic [3:0]      w_raw;
    logic [3:0]      w_dly;

    assign w_tick    = (r_div_cnt == c_dw'(CLK_DIV - 1));
    assign w_div_nxt = w_tick ? '0 : r_div_cnt + c_dw'(1);

    // Pixel divider; vga_clk follows the divider phase it is about to enter
    always_ff @(posedge ref_clk) begin
        if (!rst) begin
            r_div_cnt <= '0;
            r_vga_clk <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_vga_clk <= (w_div_nxt < c_dw'(CLK_DIV / 2));
        end
    end

    // Run/stop state register
    always_ff @(posedge ref_clk) begin
        if (!rst) r_state <= c_st_idle;
        else      r_state <= w_state_nxt;
    end

    // Next state: stopping only takes effect at the end of a complete frame
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_tick && en)  w_state_nxt = c_st_run;
            c_st_run:   if (w_tick && !en) w_state_nxt = c_st_drain;
            c_st_drain: begin
                if (w_tick) begin
                    if (en)          w_state_nxt = c_st_run;
                    else if (w_wrap) w_state_nxt = c_st_idle;
                end
            end
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_running = (r_state == c_st_run) || (r_state == c_st_drain);
    end

    assign w_x_last = (r_x == CW'(c_h_max - 1));
    assign w_y_last = (r_y == CW'(c_v_max - 1));
    assign w_wrap   = w_x_last && w_y_last;

    // Scan counters and completed-frame counter, advancing on pixel ticks
    always_ff @(posedge ref_clk) begin
        if (!rst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_frame_cnt <= '0;
        end else if (w_tick && w_running) begin
            r_x <= w_x_last ? '0 : r_x + CW'(1);
            if (w_x_last) r_y <= w_y_last ? '0 : r_y + CW'(1);
            if (w_wrap)   r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // Undelayed timing decode; everything reads inactive while idle
    always_comb begin
        w_active = w_running && (32'(r_x) < H_ACTIVE) && (32'(r_y) < V_ACTIVE);
        w_hs_act = w_running && (32'(r_x) >= c_hs_beg) && (32'(r_x) < c_hs_end);
        w_vs_act = w_running && (32'(r_y) >= c_vs_beg) && (32'(r_y) < c_vs_end);
        w_raw    = {w_hs_act ? c_h_on : ~c_h_on,
                    w_vs_act ? c_v_on : ~c_v_on,
                    ~(w_hs_act | w_vs_act),
                    w_active};
    end

    generate
        if (PIPE == 0) begin : g_pipe_bypass
            assign w_dly = w_raw;
        end else begin : g_pipe_regs
            logic [3:0] r_stage [PIPE];
            // Pixel-rate delay line aligning sync/blank with the pixel drawer
            always_ff @(posedge ref_clk) begin
                if (!rst) begin
                    for (int i = 0; i < PIPE; i++) r_stage[i] <= c_inact;
                end else if (w_tick) begin
                    r_stage[0] <= w_raw;
                    for (int i = 1; i < PIPE; i++) r_stage[i] <= r_stage[i-1];
                end
            end
            assign w_dly = r_stage[PIPE-1];
        end
    endgenerate

    assign vga_clk     = r_vga_clk;
    assign pix_en      = w_tick;
    assign x           = r_x;
    assign y           = r_y;
    assign active      = w_active;
    assign line_start  = w_tick && w_running && (r_x == '0);
    assign frame_start = w_tick && w_running && (r_x == '0) && (r_y == '0);
    assign h_sync      = w_dly[3];
    assign v_sync      = w_dly[2];
    assign sync_b      = w_dly[1];
    assign blank_b     = w_dly[0];
    assign frame_cnt   = r_frame_cnt;
    assign running     = w_running;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator: the next-generation replacement for the fixed 640x480 controller and its clock divider. It derives a pixel-rate enable and a divided `vga_clk` from `ref_clk`, runs synchronously-reset horizontal and vertical counters with fully parametrised porch, sync and polarity timing, and provides line/frame strobes and a frame counter. Sync and blank outputs are delayed by a parametrised number of pixel stages so they line up with a pipelined pixel drawer. A frame-boundary run/stop state machine lets the game logic stop scan-out cleanly instead of cutting a frame short.

## Interface
Parameters:
- `CLK_DIV`, 2: ref_clk cycles per pixel; must be ≥2.
- `H_ACTIVE`, 640 / `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal timing in pixels.
- `V_ACTIVE`, 480 / `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical timing in lines.
- `H_POL`, 0 / `V_POL`, 0: sync active level (0 = active-low).
- `PIPE`, 2: pixel-stage delay applied to sync/blank outputs; 0 to 7.
- `CW`, 10: x/y counter width; must hold H_MAX-1 and V_MAX-1.

Ports:
- `ref_clk`  in  1  sole clock, 50 MHz.
- `rst`  in  1  reset, synchronous, active-low.
- `en`  in  1  run request, level-sensitive.
- `vga_clk`  out  1  divided pixel clock for the DAC.
- `pix_en`  out  1  one-ref_clk-cycle pixel tick.
- `x`, `y`  out  CW  current pixel position, undelayed.
- `active`  out  1  x<H_ACTIVE && y<V_ACTIVE && running, undelayed.
- `line_start`, `frame_start`  out  1  pixel-tick strobes.
- `h_sync`, `v_sync`, `sync_b`, `blank_b`  out  1  delayed by PIPE pixel stages.
- `frame_cnt`  out  16  completed frames, modulo 2^16.
- `running`  out  1  high in RUN or DRAIN.

## Operation
- H_MAX = H_ACTIVE+H_FP+H_SYNC+H_BP; V_MAX is defined likewise.
- Divider: `div_cnt` counts 0..CLK_DIV-1 and wraps. tick = (div_cnt==CLK_DIV-1); `pix_en` = tick.
- `vga_clk` is registered high while div_cnt < CLK_DIV/2 (integer division) and low otherwise. For odd CLK_DIV the low phase is longer.
- State machine:
  - IDLE: counters held at 0.
  - IDLE→RUN on a tick with en=1.
  - RUN→DRAIN on any tick with en=0.
  - DRAIN→RUN on a tick with en=1, with no disturbance to the counters.
  - DRAIN→IDLE on the tick that wraps (H_MAX-1, V_MAX-1) to (0,0).
- Counters advance on every tick in RUN or DRAIN:
  - x increments and wraps to 0 at H_MAX-1.
  - y increments on the x wrap and wraps to 0 at V_MAX-1.
  - `frame_cnt` increments on the combined wrap, in either RUN or DRAIN.
- Raw sync:
  - hs_act when H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC.
  - vs_act is the same form on y.
- Output levels:
  - h_sync = hs_act ? H_POL : ~H_POL; v_sync is the same with V_POL.
  - sync_b = ~(hs_act|vs_act).
  - blank_b = active.
- In IDLE the raw values are forced inactive: syncs at their inactive level, blank_b=0, sync_b=1.
- Delay line: PIPE registers per signal, shifting only on tick. PIPE=0 gives a combinational path from the raw values.
- Strobes:
  - line_start = tick && running && x==0.
  - frame_start = line_start && y==0.

## Timing
- Reset, on the first ref_clk edge with rst=0:
  - div_cnt=0, state IDLE, x=y=0, frame_cnt=0, vga_clk=0.
  - All delay stages inactive: h_sync=~H_POL, v_sync=~V_POL, blank_b=0, sync_b=1.
  - Strobes 0, running=0.
- Reset mid-frame takes priority over everything and gives the same values one edge later.
- x/y change on the ref_clk edge where tick=1 and stay stable for CLK_DIV cycles. Consumers sample on pix_en.
- Delayed outputs correspond to the (x,y) from PIPE ticks earlier, i.e. latency PIPE×CLK_DIV ref_clk cycles.
- en is sampled only on ticks. Deassertion mid-frame completes the frame: the last drained pixel is (H_MAX-1, V_MAX-1).
- Simultaneous en=1 and final wrap in DRAIN: go to RUN, with no idle gap.
- frame_cnt wraps from 0xFFFF to 0x0000.

## Test plan
- Reset check: hold rst=0 for 3 cycles, release with en=0 → all outputs at reset values; x=y=0 indefinitely; pix_en pulses every 2nd cycle.
- Default frame: en=1 → frame_start every 420000 ticks (840000 ref_clk cycles).
  - h_sync low for x 656..751 (delayed 2 ticks); v_sync low for lines 490..491.
  - frame_cnt=1 after the first full frame.
- Small config, quick sim: H 8/2/2/2, V 4/1/1/1, PIPE=0, CLK_DIV=3 → 14×7=98 ticks per frame.
  - vga_clk high 1 cycle, low 2 cycles.
  - blank_b=1 exactly for x<8, y<4.
- Drain: deassert en at y=3 → counters finish to (13,6), wrap to (0,0), IDLE.
  - running=0 and frame_cnt incremented by 1.
  - Reassert en → frame_start on the next tick.
- Polarity/pipeline: H_POL=1, PIPE=5 → h_sync high for sync pixels and appears exactly 5 ticks after the raw hs_act; idle level 0.
- Mid-frame reset: rst=0 at x=300, y=200 → next edge x=y=0, state IDLE, delay line flushed to inactive, frame_cnt=0.
